// File: rtl/arm_seq_ctrl.sv
// Fetch/execute sequencer for the Harvard non-pipelined CPU: owns pc, inst and zero,
// fetches over a valid handshake and stalls loads in EXEC2 until data memory responds.
module arm_seq_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic        dmem_req,
    input  logic        dmem_valid,
    input  logic [15:0] alu_d_out,
    output logic [15:0] inst,
    output logic [2:0]  state,
    output logic [15:0] pc,
    output logic        zero,
    output logic        halted
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC1 = 3'd2,
        ST_EXEC2 = 3'd3,
        ST_HALT  = 3'd4
    } fsm_e;

    typedef enum logic [2:0] {
        OP_ALU  = 3'd0,
        OP_LDR  = 3'd1,
        OP_NOP  = 3'd2,
        OP_HALT = 3'd3,
        OP_JMP  = 3'd4,
        OP_BZ   = 3'd5
    } op_e;

    fsm_e        fsm_q, fsm_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic        zero_q, zero_d;
    logic [2:0]  state_q;
    logic        imem_req_q;
    logic        dmem_req_q;
    logic        halted_q;
    op_e         op_s;
    logic [15:0] target_s;

    function automatic op_e decode_op(input logic [3:0] opc);
        op_e r;
        case (opc)
            4'b1110: r = OP_LDR;
            4'b0000: r = OP_NOP;
            4'b0001: r = OP_HALT;
            4'b0100: r = OP_JMP;
            4'b0101: r = OP_BZ;
            // 001x moves and 011x are single-cycle with no sequencer effect
            4'b0010, 4'b0011, 4'b0110, 4'b0111: r = OP_NOP;
            default: r = OP_ALU;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] sext12(input logic [11:0] imm);
        return {{4{imm[11]}}, imm};
    endfunction

    function automatic logic [2:0] phase_onehot(input fsm_e s);
        logic [2:0] r;
        case (s)
            ST_FETCH: r = 3'b001;
            ST_EXEC1: r = 3'b010;
            ST_EXEC2: r = 3'b100;
            default:  r = 3'b000;
        endcase
        return r;
    endfunction

    assign op_s     = decode_op(inst_q[15:12]);
    assign target_s = pc_q + sext12(inst_q[11:0]);

    // Next-state and datapath register update selection.
    always_comb begin
        fsm_d  = fsm_q;
        pc_d   = pc_q;
        inst_d = inst_q;
        zero_d = zero_q;
        case (fsm_q)
            ST_IDLE: begin
                if (run) begin
                    fsm_d = ST_FETCH;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    inst_d = imem_rdata;
                    pc_d   = pc_q + 16'h0001;
                    fsm_d  = ST_EXEC1;
                end else begin
                    fsm_d = ST_FETCH;
                end
            end
            ST_EXEC1: begin
                case (op_s)
                    OP_ALU: begin
                        zero_d = (alu_d_out == 16'h0000);
                        fsm_d  = ST_FETCH;
                    end
                    OP_LDR:  fsm_d = ST_EXEC2;
                    OP_JMP: begin
                        pc_d  = target_s;
                        fsm_d = ST_FETCH;
                    end
                    OP_BZ: begin
                        if (zero_q) begin
                            pc_d = target_s;
                        end else begin
                            pc_d = pc_q;
                        end
                        fsm_d = ST_FETCH;
                    end
                    OP_HALT: fsm_d = ST_HALT;
                    default: fsm_d = ST_FETCH;
                endcase
            end
            ST_EXEC2: begin
                if (dmem_valid) begin
                    fsm_d = ST_FETCH;
                end else begin
                    fsm_d = ST_EXEC2;
                end
            end
            ST_HALT: fsm_d = ST_HALT;
            default: fsm_d = ST_IDLE;
        endcase
    end

    // State, datapath and output registers; outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q      <= ST_IDLE;
            pc_q       <= RESET_PC;
            inst_q     <= 16'h0000;
            zero_q     <= 1'b0;
            state_q    <= 3'b000;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            zero_q     <= zero_d;
            state_q    <= phase_onehot(fsm_d);
            imem_req_q <= (fsm_d == ST_FETCH);
            dmem_req_q <= (fsm_d == ST_EXEC2);
            halted_q   <= (fsm_d == ST_HALT);
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign dmem_req  = dmem_req_q;
    assign inst      = inst_q;
    assign state     = state_q;
    assign pc        = pc_q;
    assign zero      = zero_q;
    assign halted    = halted_q;

endmodule
